ni_read_rqst_queue: RTL and testbench

- Small synchronous FIFO in the PE network-interface input path.
- Captures READ packets arriving from the router, queues their activation addresses, and presents them one at a time to the PE read logic.
- Each request leaves when the outgoing router path is ready.
- Each dequeue (read_rqst_read_en) is used by the NI input unit to return one upstream credit.

---
 rtl/ni_read_rqst_queue_pkg.sv | 39 +++
 rtl/ni_read_rqst_queue_sync_fifo.sv | 84 ++++++++
 rtl/ni_read_rqst_queue.sv | 73 +++++++
 tb/tb_ni_read_rqst_queue.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/ni_read_rqst_queue_pkg.sv
// Shared router/PE definitions for the NI read-request queue: flit field
// layout, route_info codes and the activation address width.
package ni_read_rqst_queue_pkg;

  localparam int ROUTER_INFO_WIDTH = 4;
  localparam int ROUTER_ADDR_WIDTH = 16;
  localparam int ROUTER_DATA_WIDTH = 16;
  localparam int ROUTER_WIDTH      = ROUTER_INFO_WIDTH + ROUTER_ADDR_WIDTH + ROUTER_DATA_WIDTH;

  // Field bit positions inside a flit: info [35:32], addr [31:16], data [15:0]
  localparam int ROUTER_DATA_LSB = 0;
  localparam int ROUTER_DATA_MSB = ROUTER_DATA_LSB + ROUTER_DATA_WIDTH - 1;
  localparam int ROUTER_ADDR_LSB = ROUTER_DATA_MSB + 1;
  localparam int ROUTER_ADDR_MSB = ROUTER_ADDR_LSB + ROUTER_ADDR_WIDTH - 1;
  localparam int ROUTER_INFO_LSB = ROUTER_ADDR_MSB + 1;
  localparam int ROUTER_INFO_MSB = ROUTER_INFO_LSB + ROUTER_INFO_WIDTH - 1;

  // Activation number bus width (PeActNoBus)
  localparam int PE_ACT_NO_WIDTH = 6;

  // route_info codes carried in the flit header
  typedef enum logic [ROUTER_INFO_WIDTH-1:0] {
    ROUTER_INFO_NONE      = 4'h0,
    ROUTER_INFO_CONFIG    = 4'h1,
    ROUTER_INFO_CALC      = 4'h2,
    ROUTER_INFO_BROADCAST = 4'h3,
    ROUTER_INFO_WRITE     = 4'h4,
    ROUTER_INFO_READ      = 4'h5,
    ROUTER_INFO_RESULT    = 4'h6
  } router_info_e;

  // Activation address carried by a read request: route_addr[6:1]
  function automatic logic [PE_ACT_NO_WIDTH-1:0] read_act_addr(
    input logic [ROUTER_ADDR_WIDTH-1:0] route_addr
  );
    return route_addr[PE_ACT_NO_WIDTH:1];
  endfunction

endpackage

// File: rtl/ni_read_rqst_queue_sync_fifo.sv
// Small register-based synchronous FIFO: per-slot storage, wrapping read and
// write pointers and an occupancy count. Head is visible combinationally.
module ni_read_rqst_queue_sync_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] slot_q [DEPTH];

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CNT_W'(DEPTH));

  // A pop only happens with data present; a push into a full queue is only
  // accepted when the same edge frees the head slot.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  assign rd_data = slot_q[rd_ptr_reg];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [WIDTH-1:0] slot_reg;
      // Capture the incoming word when this slot is the write target
      always_ff @(posedge clk) begin
        if (wr_en && (wr_ptr_reg == PTR_W'(gi))) begin
          slot_reg <= wr_data;
        end
      end
      assign slot_q[gi] = slot_reg;
    end
  endgenerate

  // Occupancy is unchanged when push and pop coincide
  always_comb begin
    count_next = count_reg;
    case ({wr_en, rd_en})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Pointer and count state; pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

`ifndef SYNTHESIS
  // Overflow means upstream credit flow is broken; the request is dropped
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && full && !rd_en))
        else $error("ni_read_rqst_queue: overflow, request dropped at %0t", $time);
    end
  end
`endif

endmodule

// File: rtl/ni_read_rqst_queue.sv
// NI read-request queue: decodes READ flits from the router, queues their
// activation addresses and issues them one at a time while the outgoing
// router path is ready. Each issue (read_rqst_read_en) returns one credit.
// Optional macro READ_RQST_BYPASS_EN: a READ arriving at an empty queue with
// router_rdy high is issued in the same cycle without being stored.
module ni_read_rqst_queue
  import ni_read_rqst_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = PE_ACT_NO_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_data_valid,
  input  logic [ROUTER_WIDTH-1:0] in_data,
  input  logic                    router_rdy,
  output logic                    read_rqst_read_en,
  output logic                    ni_read_rqst,
  output logic [ADDR_W-1:0]       ni_read_addr
);

  logic [ROUTER_INFO_WIDTH-1:0] route_info;
  logic [ROUTER_ADDR_WIDTH-1:0] route_addr;
  logic [ADDR_W-1:0]            req_addr;
  logic                         is_read;
  logic                         fifo_push;
  logic                         fifo_pop;
  logic [ADDR_W-1:0]            head_addr;
  logic                         empty;
  logic                         full;
  logic                         unused_bits;

  assign route_info = in_data[ROUTER_INFO_MSB:ROUTER_INFO_LSB];
  assign route_addr = in_data[ROUTER_ADDR_MSB:ROUTER_ADDR_LSB];
  assign req_addr   = ADDR_W'(read_act_addr(route_addr));
  assign is_read    = in_data_valid && (route_info == ROUTER_INFO_READ);

  // Payload data, full state and the ignored address bits play no part here
  assign unused_bits = ^{in_data[ROUTER_DATA_MSB:ROUTER_DATA_LSB], full,
                         route_addr[ROUTER_ADDR_WIDTH-1:PE_ACT_NO_WIDTH+1], route_addr[0]};

  // Issue handshake and queue control; outputs are combinational from state
  always_comb begin
    fifo_pop          = !empty && router_rdy;
    fifo_push         = is_read;
    ni_read_rqst      = !empty;
    read_rqst_read_en = !empty && router_rdy;
    ni_read_addr      = empty ? '0 : head_addr;
`ifdef READ_RQST_BYPASS_EN
    if (empty && is_read && router_rdy) begin
      fifo_push         = 1'b0;
      ni_read_rqst      = 1'b1;
      read_rqst_read_en = 1'b1;
      ni_read_addr      = req_addr;
    end
`endif
  end

  ni_read_rqst_queue_sync_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (req_addr),
    .pop     (fifo_pop),
    .rd_data (head_addr),
    .empty   (empty),
    .full    (full)
  );

endmodule

// File: tb/tb_ni_read_rqst_queue.sv
// Directed bench for ni_read_rqst_queue (default build, no bypass).
module tb_ni_read_rqst_queue;
  import ni_read_rqst_queue_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    in_data_valid = 1'b0;
  logic [ROUTER_WIDTH-1:0] in_data = '0;
  logic                    router_rdy = 1'b0;
  logic                    read_rqst_read_en;
  logic                    ni_read_rqst;
  logic [5:0]              ni_read_addr;

  int n_cmp = 0;
  int n_bad = 0;
  int en_cycles;

  always #5 clk = ~clk;

  ni_read_rqst_queue #(.DEPTH(4), .ADDR_W(6)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_data_valid     (in_data_valid),
    .in_data           (in_data),
    .router_rdy        (router_rdy),
    .read_rqst_read_en (read_rqst_read_en),
    .ni_read_rqst      (ni_read_rqst),
    .ni_read_addr      (ni_read_addr)
  );

  function automatic logic [ROUTER_WIDTH-1:0] flit(input logic [3:0] info, input logic [15:0] addr);
    return {info, addr, 16'hBEEF};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_bad++;
        $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
    $display("check %-16s got %0h expected %0h", tag, obs, exp);
  endtask

  // Check all three outputs after inputs settle
  task automatic chk3(input string tag, input logic rq, input logic en, input logic [5:0] ad);
    #1;
    chk({tag, ".rqst"}, 32'(ni_read_rqst), 32'(rq));
    chk({tag, ".en"}, 32'(read_rqst_read_en), 32'(en));
    chk({tag, ".addr"}, 32'(ni_read_addr), 32'(ad));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] info, input logic [15:0] addr, input logic rdy);
    in_data_valid = v;
    in_data       = flit(info, addr);
    router_rdy    = rdy;
  endtask

  initial begin
    // Reset then idle
    #12 rst = 1'b0;
    tick();
    chk3("reset_idle", 1'b0, 1'b0, 6'd0);

    // Single READ, addr 0x000A -> 5, with router ready
    drive(1'b1, ROUTER_INFO_READ, 16'h000A, 1'b1);
    chk3("single_pre", 1'b0, 1'b0, 6'd0);
    tick();
    drive(1'b0, ROUTER_INFO_NONE, 16'h0000, 1'b1);
    chk3("single_issue", 1'b1, 1'b1, 6'd5);
    tick();
    chk3("single_empty", 1'b0, 1'b0, 6'd0);

    // Fill with 2,4,6,8 (-> 1,2,3,4) while router not ready
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, ROUTER_INFO_READ, 16'(2 * i), 1'b0);
      tick();
    end
    drive(1'b0, ROUTER_INFO_NONE, 16'h0000, 1'b0);
    chk3("full_hold", 1'b1, 1'b0, 6'd1);
    tick();
    tick();
    chk3("full_hold2", 1'b1, 1'b0, 6'd1);

    // Drain in order with router ready
    router_rdy = 1'b1;
    en_cycles = 0;
    for (int i = 1; i <= 4; i++) begin
      chk3("drain", 1'b1, 1'b1, 6'(i));
      if (read_rqst_read_en) en_cycles++;
      tick();
    end
    chk3("drain_empty", 1'b0, 1'b0, 6'd0);
    chk("drain_en_cycles", 32'(en_cycles), 32'd4);

    // Refill to full, then push addr 20 (-> 10) together with a pop
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, ROUTER_INFO_READ, 16'(2 * i), 1'b0);
      tick();
    end
    drive(1'b1, ROUTER_INFO_READ, 16'd20, 1'b1);
    chk3("full_pushpop", 1'b1, 1'b1, 6'd1);
    tick();
    drive(1'b0, ROUTER_INFO_NONE, 16'h0000, 1'b0);
    chk3("after_pushpop", 1'b1, 1'b0, 6'd2);
    router_rdy = 1'b1;
    chk3("pp_drain0", 1'b1, 1'b1, 6'd2);
    tick();
    chk3("pp_drain1", 1'b1, 1'b1, 6'd3);
    tick();
    chk3("pp_drain2", 1'b1, 1'b1, 6'd4);
    tick();
    chk3("pp_drain3", 1'b1, 1'b1, 6'd10);
    tick();
    chk3("pp_empty", 1'b0, 1'b0, 6'd0);

    // Non-READ flits are ignored
    drive(1'b1, ROUTER_INFO_CONFIG, 16'h0002, 1'b0);
    tick();
    drive(1'b1, ROUTER_INFO_CALC, 16'h0004, 1'b0);
    tick();
    drive(1'b1, ROUTER_INFO_BROADCAST, 16'h0006, 1'b0);
    tick();
    drive(1'b0, ROUTER_INFO_NONE, 16'h0000, 1'b0);
    chk3("non_read", 1'b0, 1'b0, 6'd0);

    // Ignored address bits: 0xFF83 -> bits[6:1] = 1
    drive(1'b1, ROUTER_INFO_READ, 16'hFF83, 1'b0);
    tick();
    drive(1'b0, ROUTER_INFO_NONE, 16'h0000, 1'b0);
    chk3("addr_mask", 1'b1, 1'b0, 6'd1);
    router_rdy = 1'b1;
    tick();
    router_rdy = 1'b0;
    chk3("addr_mask_empty", 1'b0, 1'b0, 6'd0);

    // Four entries, pop one, then async reset with three remaining
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, ROUTER_INFO_READ, 16'(2 * i), 1'b0);
      tick();
    end
    drive(1'b0, ROUTER_INFO_NONE, 16'h0000, 1'b1);
    tick();
    router_rdy = 1'b1;
    chk3("mid_drain", 1'b1, 1'b1, 6'd2);
    #2 rst = 1'b1;
    chk3("async_rst", 1'b0, 1'b0, 6'd0);
    tick();
    #2 rst = 1'b0;
    tick();
    chk3("post_rst", 1'b0, 1'b0, 6'd0);
    drive(1'b1, ROUTER_INFO_READ, 16'h000E, 1'b1);
    tick();
    drive(1'b0, ROUTER_INFO_NONE, 16'h0000, 1'b1);
    chk3("post_rst_issue", 1'b1, 1'b1, 6'd7);
    tick();
    chk3("post_rst_empty", 1'b0, 1'b0, 6'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, expected finish before %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
